// File: rtl/seg_scan_multi.sv
// Multiplexed 7-segment scanner: per-slot blanking, 16-level PWM, per-digit enable/blink,
// and inputs shadowed at frame start so a frame is never drawn from mixed data.
module seg_scan_multi #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned SYSCLK         = 50000000,
  parameter int unsigned SCAN_FREQ      = 200,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter int unsigned BLINK_CYCLES   = 12500000,
  parameter int unsigned SEL_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*DIGITS-1:0] seg_data_bus,
  input  logic [DIGITS-1:0]   digit_en,
  input  logic [DIGITS-1:0]   blink_mask,
  input  logic [3:0]          brightness,
  output logic [DIGITS-1:0]   seg_sel,
  output logic [7:0]          seg_data,
  output logic                frame_done
);

  localparam int unsigned SlotCycles = SYSCLK / (SCAN_FREQ * DIGITS);
  localparam int unsigned SlotW      = (SlotCycles > 1) ? $clog2(SlotCycles) : 1;
  localparam int unsigned IdxW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BlinkW     = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DIGITS-1:0] SelOff = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;
  localparam logic [7:0]        SegOff = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  logic [SlotW-1:0]    slot_q, slot_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          pwm_q, pwm_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  logic [8*DIGITS-1:0] sh_bus_q;
  logic [DIGITS-1:0]   sh_en_q, sh_mask_q;
  logic [3:0]          sh_bright_q;

  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          data_q, data_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_wrap, last_idx, blink_wrap, frame_start, lit;
  logic [8*DIGITS-1:0] cur_bus;
  logic [DIGITS-1:0]   cur_en, cur_mask, onehot;
  logic [3:0]          cur_bright;
  logic [7:0]          cur_pat;

  always_comb begin
    slot_wrap   = (slot_q == SlotW'(SlotCycles - 1));
    last_idx    = (idx_q == IdxW'(DIGITS - 1));
    slot_d      = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d       = idx_q;
    if (slot_wrap) idx_d = last_idx ? '0 : idx_q + 1'b1;
    // PWM phase restarts on the first cycle of every on phase
    pwm_d       = (slot_d == SlotW'(BLANK_CYCLES)) ? 4'd0 : pwm_q + 4'd1;
    blink_wrap  = (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1));
    blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
  end

  // At frame start the live inputs are used directly, matching what gets latched this cycle.
  always_comb begin
    frame_start = (slot_q == '0) && (idx_q == '0);
    cur_bus     = frame_start ? seg_data_bus : sh_bus_q;
    cur_en      = frame_start ? digit_en     : sh_en_q;
    cur_mask    = frame_start ? blink_mask   : sh_mask_q;
    cur_bright  = frame_start ? brightness   : sh_bright_q;
    cur_pat     = cur_bus[{idx_q, 3'b000} +: 8];
    onehot      = DIGITS'(1) << idx_q;
    lit         = (slot_q >= SlotW'(BLANK_CYCLES)) && cur_en[idx_q] &&
                  !(cur_mask[idx_q] && blink_phase_q) && (pwm_q <= cur_bright);
    sel_d        = SelOff;
    data_d       = SegOff;
    if (lit) begin
      sel_d  = SelOff ^ onehot;
      data_d = cur_pat;
    end
    frame_done_d = slot_wrap && last_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_bus_q      <= '0;
      sh_en_q       <= '0;
      sh_mask_q     <= '0;
      sh_bright_q   <= '0;
      sel_q         <= SelOff;
      data_q        <= SegOff;
      frame_done_q  <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (frame_start) begin
        sh_bus_q    <= seg_data_bus;
        sh_en_q     <= digit_en;
        sh_mask_q   <= blink_mask;
        sh_bright_q <= brightness;
      end
      sel_q         <= sel_d;
      data_q        <= data_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg_sel    = sel_q;
  assign seg_data   = data_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_multi.sv
// Scoreboard bench for seg_scan_multi: the driver pushes the expected output of every cycle,
// a negedge monitor pops and compares.
module tb_seg_scan_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus;
  logic [3:0]  en, mask, br;
  logic [3:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_done;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] data;
    logic       fd;
    int         phase;
    int         n;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int n = 0;
  int phase = 0;

  // Bench copy of what the DUT should have latched at the last frame start
  logic [31:0] sh_bus;
  logic [3:0]  sh_en, sh_mask, sh_br;

  seg_scan_multi #(
    .DIGITS        (4),
    .SYSCLK        (4000),
    .SCAN_FREQ     (50),
    .BLANK_CYCLES  (2),
    .BLINK_CYCLES  (200),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_data_bus(bus),
    .digit_en    (en),
    .blink_mask  (mask),
    .brightness  (br),
    .seg_sel     (seg_sel),
    .seg_data    (seg_data),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Expected outputs after the n-th edge since reset release (20-cycle slots, 4 digits)
  function automatic exp_t model(input int cyc);
    exp_t e;
    int pos, d, pwm;
    logic bph;
    pos = cyc % 20;
    d   = (cyc / 20) % 4;
    bph = ((cyc / 200) % 2) == 1;
    e.sel   = 4'hF;
    e.data  = 8'hFF;
    e.fd    = (cyc % 80) == 79;
    e.phase = phase;
    e.n     = cyc;
    if (pos >= 2) begin
      pwm = (pos - 2) % 16;
      if (sh_en[d] && !(sh_mask[d] && bph) && (pwm <= int'(sh_br))) begin
        e.sel  = ~(4'b0001 << d);
        e.data = sh_bus[d*8 +: 8];
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (n % 80 == 0) begin
      sh_bus  = bus;
      sh_en   = en;
      sh_mask = mask;
      sh_br   = br;
    end
    exp_q.push_back(model(n));
    n++;
  endtask

  // rst must already be 1; checks the reset edge then releases it
  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = 4'hF; e.data = 8'hFF; e.fd = 1'b0; e.phase = phase; e.n = -1;
    exp_q.push_back(e);
    rst = 1'b0;
    n = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (seg_sel !== e.sel || seg_data !== e.data || frame_done !== e.fd) begin
        failures++;
        $display("FAIL phase%0d_n%0d: sel=%h data=%h fd=%b, required sel=%h data=%h fd=%b",
                 e.phase, e.n, seg_sel, seg_data, frame_done, e.sel, e.data, e.fd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    bus  = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    en   = 4'hF;
    mask = 4'h0;
    br   = 4'd15;
    repeat (2) @(posedge clk);
    // Phase 0: reset, then three frames of plain scanning; digit 3 changes during frame 1 slot 1
    phase = 0;
    do_reset();
    for (int i = 0; i < 240; i++) begin
      step();
      if (i == 100) bus[31:24] = 8'h99;
    end
    // Phase 1: brightness 3 for one frame
    phase = 1;
    br = 4'd3;
    for (int i = 0; i < 80; i++) step();
    // Phase 2: part of the next frame, then reset in the middle of slot 2
    phase = 2;
    for (int i = 0; i < 45; i++) step();
    mask = 4'b0010;
    en   = 4'b1011;
    br   = 4'd15;
    rst  = 1'b1;
    do_reset();
    // Phase 3: blink on digit 1, digit 2 disabled, across several blink windows
    phase = 3;
    for (int i = 0; i < 480; i++) step();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_multi.md
Name: seg_scan_multi

Overview:
- Parametrised successor to the fixed 6-digit multiplexed 7-segment scanner.
- Time-multiplexes DIGITS digit patterns onto one shared segment bus with per-digit select lines.
- Adds four features:
  - an inter-digit blanking interval (anti-ghosting);
  - global 16-level PWM brightness;
  - per-digit enable and blink;
  - frame-synchronous shadow latching, so display updates never tear.
- Sits between display-formatting logic (BCD/char decoders, RTC/counter front ends) and the board's digit/segment pins.

Parameters:
- DIGITS, 6, number of digits scanned; legal 1..16.
- SYSCLK, 50000000, clk frequency in Hz.
- SCAN_FREQ, 200, full-frame refresh rate in Hz.
- BLANK_CYCLES, 16, cycles of all-off at the start of each digit slot; must be < SLOT_CYCLES.
- BLINK_CYCLES, 12500000, cycles per blink half-period (default gives 2 Hz blink).
- SEL_ACTIVE_LOW, 1, 1 = digit select is active-low; 0 = active-high.
- SEG_ACTIVE_LOW, 1, 1 = segment bus off value is all ones; 0 = off value is all zeros.
- Derived: SLOT_CYCLES = SYSCLK/(SCAN_FREQ*DIGITS).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- seg_data_bus  in  8*DIGITS  digit k pattern at bits [8k+7:8k]; panel polarity, passed through unmodified; digit 0 = rightmost select.
- digit_en  in  DIGITS  1 = digit displayed; 0 = digit blanked, slot time kept.
- blink_mask  in  DIGITS  1 = digit blanked during the blink-off phase.
- brightness  in  4  0 = 1/16 duty ... 15 = 16/16 duty, within the on-phase.
- seg_sel  out  DIGITS  registered digit select.
- seg_data  out  8  registered segment bus.
- frame_done  out  1  one-cycle pulse at the end of the last digit slot.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-frame):
  - seg_sel = all inactive (all ones if SEL_ACTIVE_LOW, else all zeros).
  - seg_data = OFF (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
  - frame_done = 0.
  - Slot counter, digit index, PWM counter, blink counter and blink phase = 0.
  - Shadow registers cleared to: all digits disabled, brightness 0.
- Slot counter:
  - Counts 0..SLOT_CYCLES-1, then wraps to 0.
  - On wrap, digit index advances; DIGITS-1 wraps to 0.
- Frame start = slot counter 0 and index 0, including the first cycle after reset.
  - At frame start, seg_data_bus, digit_en, blink_mask and brightness are captured into shadow registers.
  - Inputs changing mid-frame have no effect until the next frame start.
- Blank phase (slot counter < BLANK_CYCLES): seg_sel all inactive, seg_data OFF.
- On phase (slot counter ≥ BLANK_CYCLES):
  - The 4-bit PWM counter resets to 0 on entry to the on phase and increments every cycle, wrapping at 15.
  - The digit is lit when all of the following hold:
    - shadow digit_en[idx] = 1;
    - NOT (shadow blink_mask[idx] AND blink_phase);
    - pwm_cnt ≤ shadow brightness.
  - Lit: seg_sel has only bit idx active; seg_data = shadow pattern idx.
  - Unlit: seg_sel all inactive, seg_data OFF.
- Blink: free-running counter 0..BLINK_CYCLES-1; blink_phase toggles on wrap. Starts at 0 (visible) after reset and runs independently of the scan.
- Latency: outputs are registered, so they reflect the counter state of the previous cycle (1-cycle latency).
  - Exactly one select line is active at any time, or none.
  - Select and segment bus change on the same edge.
- frame_done: asserted for exactly one cycle, on the cycle the outputs show the final cycle of slot DIGITS-1.
- Degenerate cases:
  - DIGITS=1: index stays 0 and frame_done pulses every slot.
  - brightness=15: lit for the entire on phase.

Test Plan:
- Common setup: DIGITS=4, SYSCLK=4000, SCAN_FREQ=50 (so SLOT_CYCLES=20), BLANK_CYCLES=2, BLINK_CYCLES=200, active-low polarity; inputs all enabled, blink_mask=0, brightness=15.
- Scan order: patterns 8'hC0, 8'hF9, 8'hA4, 8'hB0 on digits 0..3 -> per slot, 2 cycles of seg_sel=4'hF/seg_data=8'hFF, then 18 cycles of seg_sel=4'hE,D,B,7 with the matching pattern; frame_done high once every 80 cycles.
- Reset: assert rst for 1 cycle mid-slot 2 -> on the next edge seg_sel=4'hF, seg_data=8'hFF, frame_done=0; scanning restarts at digit 0 blank phase.
- Tear-free update: change digit 3 pattern to 8'h99 during slot 1 -> slot 3 of the current frame still shows 8'hB0; the next frame shows 8'h99.
- Brightness: brightness=3 -> in each on phase, digit lit on cycles 0-3, dark on 4-15, lit on 16-17.
- Blink and enable: blink_mask=4'b0010 and digit_en=4'b1011 -> digit 2 is never lit, yet its slot stays 20 cycles; digit 1 is dark for alternating 200-cycle windows; digits 0 and 3 are unaffected.
